// File: rtl/fp_pkg.sv
// Shared constants, special-value encoding and format helpers for the
// floating-point add/sub pipeline.
package fp_pkg;

  localparam int unsigned FLG_INV  = 3;
  localparam int unsigned FLG_OVF  = 2;
  localparam int unsigned FLG_UNF  = 1;
  localparam int unsigned FLG_ZERO = 0;

  typedef enum logic [1:0] {NORMAL, QNAN, INF, ZERO} fp_special_e;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned fp_exp_ones(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

  // Canonical quiet NaN, right-aligned in 64 bits; callers cast to word width.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    return (64'(fp_exp_ones(exp_w)) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for fp_addsub_pipe.
interface fp_addsub_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, result, flags
  );

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 28,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CNT_W-1:0] o_cnt
);

  always_comb begin
    o_cnt = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) o_cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-style adder/subtractor: align, add/sub, normalise/round/pack,
// with lock-step valid/ready stalling and round-to-nearest-even.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           EN,
  fp_addsub_pipe_if.slave bus
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned SW     = MAN_W + 4;
  localparam int unsigned SUMW   = MAN_W + 5;
  localparam int unsigned EW     = EXP_W + 2;
  localparam int unsigned RW     = MAN_W + 2;
  localparam int unsigned CW     = $clog2(SUMW + 1);
  localparam int unsigned SH_MAX = MAN_W + 3;
  localparam logic [W-1:0]  CANON_NAN = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [EW-1:0] EXP_INF   = EW'(fp_exp_ones(EXP_W));

  logic w_stall, w_adv;
  logic r_out_valid;
  logic [W-1:0] r_result;
  logic [3:0]   r_flags;

  assign w_stall      = (r_out_valid & ~bus.out_ready) | ~EN;
  assign w_adv        = ~w_stall;
  assign bus.in_ready = w_adv;

  // Operand capture rank: accepted beats land here so the three working
  // stages after it give an edge-N accept to edge-N+3 result.
  logic         r0_valid, r0_op;
  logic [W-1:0] r0_a, r0_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_valid <= 1'b0;
      r0_op    <= 1'b0;
      r0_a     <= '0;
      r0_b     <= '0;
    end else if (w_adv) begin
      r0_valid <= bus.in_valid;
      r0_op    <= bus.op;
      r0_a     <= bus.A;
      r0_b     <= bus.B;
    end
  end

  logic [EXP_W-1:0] w_ea, w_eb, w_ex, w_ey, w_ediff;
  logic [MAN_W-1:0] w_ma, w_mb, w_mx, w_my;
  logic             w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_a_big, w_zy;
  int unsigned      w_sh;
  logic [SW-1:0]    w_sig_x, w_sig_y0, w_sig_y;
  fp_special_e      w_kind;
  logic             w_sign;

  assign w_ea    = r0_a[W-2 -: EXP_W];
  assign w_eb    = r0_b[W-2 -: EXP_W];
  assign w_za    = (w_ea == '0);
  assign w_zb    = (w_eb == '0);
  assign w_ma    = w_za ? '0 : r0_a[MAN_W-1:0];
  assign w_mb    = w_zb ? '0 : r0_b[MAN_W-1:0];
  assign w_ia    = (w_ea == '1) && (w_ma == '0);
  assign w_ib    = (w_eb == '1) && (w_mb == '0);
  assign w_na    = (w_ea == '1) && (w_ma != '0);
  assign w_nb    = (w_eb == '1) && (w_mb != '0);
  assign w_sa    = r0_a[W-1];
  assign w_sb    = r0_b[W-1] ^ r0_op;
  assign w_a_big = {w_ea, w_ma} >= {w_eb, w_mb};
  assign w_ex    = w_a_big ? w_ea : w_eb;
  assign w_ey    = w_a_big ? w_eb : w_ea;
  assign w_mx    = w_a_big ? w_ma : w_mb;
  assign w_my    = w_a_big ? w_mb : w_ma;
  assign w_zy    = w_a_big ? w_zb : w_za;
  assign w_ediff = w_ex - w_ey;
  assign w_sh    = (32'(w_ediff) > SH_MAX) ? SH_MAX : 32'(w_ediff);

  assign w_sig_x  = {1'b1, w_mx, 3'b000};
  assign w_sig_y0 = {~w_zy, w_my, 3'b000};
  assign w_sig_y  = (w_sig_y0 >> w_sh) | SW'(|(w_sig_y0 & ~({SW{1'b1}} << w_sh)));

  always_comb begin
    w_kind = NORMAL;
    w_sign = w_a_big ? w_sa : w_sb;
    if (w_na || w_nb || (w_ia && w_ib && (w_sa != w_sb))) begin
      w_kind = QNAN;
      w_sign = 1'b0;
    end else if (w_ia || w_ib) begin
      w_kind = INF;
      w_sign = w_ia ? w_sa : w_sb;
    end else if (w_za && w_zb) begin
      w_kind = ZERO;
      w_sign = w_sa & w_sb;
    end
  end

  logic             r1_valid, r1_sign, r1_sub;
  fp_special_e      r1_kind;
  logic [EXP_W-1:0] r1_exp;
  logic [SW-1:0]    r1_sx, r1_sy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_kind  <= NORMAL;
      r1_sign  <= 1'b0;
      r1_sub   <= 1'b0;
      r1_exp   <= '0;
      r1_sx    <= '0;
      r1_sy    <= '0;
    end else if (w_adv) begin
      r1_valid <= r0_valid;
      r1_kind  <= w_kind;
      r1_sign  <= w_sign;
      r1_sub   <= w_sa ^ w_sb;
      r1_exp   <= w_ex;
      r1_sx    <= w_sig_x;
      r1_sy    <= w_sig_y;
    end
  end

  logic [SUMW-1:0] w_sum;
  assign w_sum = r1_sub ? ({1'b0, r1_sx} - {1'b0, r1_sy}) : ({1'b0, r1_sx} + {1'b0, r1_sy});

  logic             r2_valid, r2_sign;
  fp_special_e      r2_kind;
  logic [EXP_W-1:0] r2_exp;
  logic [SUMW-1:0]  r2_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_kind  <= NORMAL;
      r2_sign  <= 1'b0;
      r2_exp   <= '0;
      r2_sum   <= '0;
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      r2_kind  <= r1_kind;
      r2_sign  <= r1_sign;
      r2_exp   <= r1_exp;
      r2_sum   <= w_sum;
    end
  end

  logic [CW-1:0] w_lz;
  logic [SW-1:0] w_norm;
  logic [EW-1:0] w_exp_n, w_exp_f;
  logic [RW-1:0] w_rnd;
  logic [MAN_W-1:0] w_man;
  logic          w_inc, w_ovf, w_unf;
  logic [W-1:0]  w_res;
  logic [3:0]    w_flg;

  fp_lzc #(.WIDTH(SUMW)) u_lzc (.i_vec(r2_sum), .o_cnt(w_lz));

  // The count spans the carry bit too, so a sum with no carry always has
  // lz >= 1 and the hidden bit needs a shift of lz-1.
  always_comb begin
    w_norm  = '0;
    w_exp_n = '0;
    if (r2_sum[SUMW-1]) begin
      w_norm  = {r2_sum[SUMW-1:2], r2_sum[1] | r2_sum[0]};
      w_exp_n = EW'(r2_exp) + EW'(1);
    end else begin
      w_norm  = SW'(r2_sum << (w_lz - CW'(1)));
      w_exp_n = EW'(r2_exp) - EW'(w_lz) + EW'(1);
    end
  end

  assign w_inc   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_rnd   = {1'b0, w_norm[SW-1:3]} + RW'(w_inc);
  assign w_man   = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
  assign w_exp_f = w_exp_n + EW'(w_rnd[MAN_W+1]);
  assign w_ovf   = $signed(w_exp_f) >= $signed(EXP_INF);
  assign w_unf   = $signed(w_exp_f) <= $signed(EW'(0));

  always_comb begin
    w_res = '0;
    w_flg = '0;
    case (r2_kind)
      QNAN: begin
        w_res          = CANON_NAN;
        w_flg[FLG_INV] = 1'b1;
      end
      INF:  w_res = {r2_sign, EXP_INF[EXP_W-1:0], {MAN_W{1'b0}}};
      ZERO: begin
        w_res           = {r2_sign, {(W-1){1'b0}}};
        w_flg[FLG_ZERO] = 1'b1;
      end
      default: begin
        if (r2_sum == '0) begin
          w_flg[FLG_ZERO] = 1'b1;
        end else if (w_ovf) begin
          w_res          = {r2_sign, EXP_INF[EXP_W-1:0], {MAN_W{1'b0}}};
          w_flg[FLG_OVF] = 1'b1;
        end else if (w_unf) begin
          w_res           = {r2_sign, {(W-1){1'b0}}};
          w_flg[FLG_UNF]  = 1'b1;
          w_flg[FLG_ZERO] = 1'b1;
        end else begin
          w_res = {r2_sign, w_exp_f[EXP_W-1:0], w_man};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_adv) begin
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        r_result <= w_res;
        r_flags  <= w_flg;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed self-checking bench for fp_addsub_pipe (single precision).
module tb_fp_addsub_pipe;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   n_cmp = 0;
  int   n_err = 0;

  fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .EN  (en),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic o, input logic [31:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.op = o; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, bus.result, exp_r);
    check({tag, "_flags"}, 32'(bus.flags), 32'(exp_f));
  endtask

  // mode 0: out_ready low for 4 cycles; mode 1: EN low for 2 cycles
  task automatic run_stream(input int mode);
    logic [31:0] vin  [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] vout [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                              32'h41000000, 32'h41200000, 32'h41400000};
    int sent = 0;
    int got = 0;
    int extra = 0;
    bit hold;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      hold = (cyc >= 5) && (cyc < ((mode == 0) ? 9 : 7));
      bus.out_ready = (mode == 0) ? !hold : 1'b1;
      en            = (mode == 1) ? !hold : 1'b1;
      #1;
      if (hold) check($sformatf("stream%0d_in_ready_c%0d", mode, cyc), 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready && en) begin
        check($sformatf("stream%0d_beat%0d", mode, got), bus.result, vout[got]);
        got++;
      end
      bus.in_valid = (sent < 6);
      if (sent < 6) begin
        bus.A = vin[sent]; bus.B = vin[sent]; bus.op = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    en = 1'b1;
    bus.out_ready = 1'b1;
    check($sformatf("stream%0d_sent", mode), 32'(sent), 32'd6);
    check($sformatf("stream%0d_got", mode), 32'(got), 32'd6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    check($sformatf("stream%0d_no_dup", mode), 32'(extra), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; en = 1'b1;
    bus.in_valid = 1'b0; bus.op = 1'b0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_single("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    run_single("x_minus_x",     32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 4'b0001);
    run_single("three_minus_1", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    run_single("rne_tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000);
    run_single("rne_round_up",  32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 4'b0000);
    run_single("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    run_single("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0100);
    run_single("nan_in",        32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_single("one_minus_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    run_single("negz_plus_negz",32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001);
    run_single("posz_minus_z",  32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0001);

    run_stream(0);
    run_stream(1);

    // Four beats with out_ready low: one parked at the output, three in flight.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.op = 1'b0;
      bus.A = 32'h3F800000; bus.B = 32'h3F800000;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_result", bus.result, 32'h40000000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_result", bus.result, 32'd0);
    check("async_rst_flags", 32'(bus.flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1 check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("post_rst_no_beats", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, pipelined floating-point adder/subtractor for the Floating ALU. It replaces the single-cycle combinational subtractor with a 3-stage pipeline: align, add/sub, then normalise/round/pack. It supports run-time add/sub selection, configurable exponent and mantissa widths, round-to-nearest-even, special-value handling and valid/ready flow control. It sits between the ALU operand registers and the result writeback mux.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width (no hidden bit); total word W = 1+EXP_W+MAN_W
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- EN  input  1  global enable; low freezes every pipeline register
- in_valid  input  1  operand beat offered
- in_ready  output  1  block accepts the beat this cycle
- op  input  1  0 = A+B, 1 = A−B
- A, B  input  W  IEEE-style operands
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- result  output  W  packed result
- flags  output  4  {invalid, overflow, underflow, zero}

## Operation
- Effective B sign = B[W-1] ^ op.
- Exponent 0 means zero; denormal inputs flush to signed zero. Denormal results flush to zero and set underflow.
- Stage 1, align:
  - Compare magnitudes {exp, man}; the larger becomes X, the smaller Y.
  - Build significands as {1, man, 3'b000} (guard/round/sticky).
  - Right-shift Y by expX−expY. The shift saturates at MAN_W+3. Bits shifted out OR into sticky.
- Stage 2:
  - Signs equal: add. Otherwise subtract Y from X; the result is never negative.
  - Keep the carry-out bit. Result sign = sign of X.
- Stage 3, normalise:
  - Carry set: shift right 1, OR the lost bit into sticky, exp+1.
  - Otherwise: left-shift by the leading-zero count, exp−lzc.
- Stage 3, round (RNE): increment when G & (R | S | LSB). A rounding carry renormalises (exp+1).
- Stage 3, exponent limits:
  - exp ≥ 2^EXP_W−1 → ±inf, overflow=1.
  - exp ≤ 0 → ±0, underflow=1.
- Exact zero result (X−X): +0, zero=1.
- Special values (decided in stage 1, carried down the pipeline):
  - Any NaN input, or inf − inf (effective): canonical qNaN = {0, all-ones exp, 1, zeros}, invalid=1.
  - Exactly one inf: that inf, with effective sign.
  - Both operands zero: +0, except (−0)+(−0) = −0.
- flags.zero is set whenever the result magnitude is zero.

## Timing
- Latency: 3 cycles from an accepted beat (in_valid & in_ready at edge N) to out_valid at edge N+3, with no stall.
- Throughput: 1 beat/cycle.
- Stall: stall = out_valid & ~out_ready, or ~EN.
  - While stalled, all stage registers and valids hold. in_ready = ~stall.
  - Bubbles do not collapse; the pipeline is a simple lock-step shift.
- result and flags stay stable while out_valid & ~out_ready.
- Reset (asynchronous, any time, including mid-operation):
  - All stage valids → 0; in-flight beats are discarded.
  - out_valid=0, result=0, flags=0.
  - in_ready=1 once rst deasserts (with EN high).
- EN low with in_valid high: no beat is accepted. The upstream must hold its beat.
- Simultaneous out_ready and in_valid on a full pipeline: the output retires and the new beat enters in the same edge.

## Structure
- Package fp_pkg holds:
  - helper functions for bias, exp-all-ones and canonical NaN, derived from EXP_W/MAN_W;
  - flag bit index constants (FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_ZERO=0);
  - the special-case encoding enum {NORMAL, QNAN, INF, ZERO}.
- Sub-module fp_lzc: parametrised leading-zero counter over MAN_W+5 bits. It is combinational and is instantiated in stage 3.
- Stage registers live in fp_addsub_pipe itself.

## Test plan
- 1.0 + 1.0 (0x3F800000, 0x3F800000, op=0):
  - result 0x40000000 exactly 3 cycles after acceptance; flags=0.
- Subtraction to exact zero and normalisation:
  - 1.5 − 1.5 (0x3FC00000 both, op=1) → 0x00000000, zero=1.
  - 3.0 − 1.0 → 0x40000000.
- Rounding:
  - 1.0 + 2^-24 (0x33800000) → 0x3F800000 (tie to even).
  - 1.0 + 1.5·2^-23 (0x34400000) → 0x3F800002.
- Specials:
  - +inf − +inf (op=1) → 0x7FC00000, invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1.
- Back-pressure and enable:
  - Stream 6 beats, hold out_ready low for 4 cycles: in_ready drops, no beat is lost or duplicated, and outputs come in order.
  - EN low for 2 cycles freezes the pipeline in the same way.
- Reset with 3 beats in flight: out_valid=0 and result=0 immediately (asynchronous); none of the 3 beats appears after reset release.
